// File: rtl/seg_debug_pkg.sv
// Shared types and the hex-to-seven-segment table for the debug display.
package seg_debug_pkg;

    typedef logic [6:0] seg_t;

    // Active-low {g,f,e,d,c,b,a}: all ones means every segment is dark.
    localparam seg_t SEG_BLANK = 7'h7F;

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

endpackage

// File: rtl/seg_debug_display_if.sv
// Debug-source side and pin side of the seven-segment debug display.
interface seg_debug_display_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int DIGITS       = 8,
    parameter int STICKY_BITS  = 8
) ();
    import seg_debug_pkg::*;

    localparam int SEL_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [NUM_CHANNELS*DIGITS*4-1:0] chan_in;
    logic [SEL_W-1:0]                 sel_in;
    logic                             freeze_in;
    logic [STICKY_BITS-1:0]           sticky_set_in;
    logic                             sticky_clr_in;
    logic [STICKY_BITS-1:0]           sticky_out;
    logic [DIGITS*4-1:0]              value_out;
    seg_t                             cat_out;
    logic [DIGITS-1:0]                an_out;

    modport master (
        output chan_in, sel_in, freeze_in, sticky_set_in, sticky_clr_in,
        input  sticky_out, value_out, cat_out, an_out
    );

    modport slave (
        input  chan_in, sel_in, freeze_in, sticky_set_in, sticky_clr_in,
        output sticky_out, value_out, cat_out, an_out
    );

endinterface

// File: rtl/seg_scan_timer.sv
// Slot counter plus digit index for the display multiplexer.
// Outputs are look-ahead: they give the values that take effect at the coming edge.
module seg_scan_timer #(
    parameter  int DIGITS      = 8,
    parameter  int SCAN_PERIOD = 100000,
    localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    output logic [IDX_W-1:0] index_out,
    output logic             last_cycle_out
);

    localparam int CNT_W = $clog2(SCAN_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign index_out      = idx_d;
    assign last_cycle_out = (cnt_d == CNT_LAST);

endmodule

// File: rtl/seg_debug_display.sv
// Selects one debug word, optionally freezes it, keeps sticky event flags and
// scans the value onto active-low seven-segment digits.
module seg_debug_display
    import seg_debug_pkg::*;
#(
    parameter int NUM_CHANNELS  = 4,
    parameter int DIGITS        = 8,
    parameter int SCAN_PERIOD   = 100000,
    parameter int STICKY_BITS   = 8,
    parameter int BLANK_LEADING = 0
) (
    input  logic clk_in,
    input  logic rst_in,
    seg_debug_display_if.slave bus
);

    localparam int WORD_W = DIGITS * 4;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [IDX_W-1:0]       index;
    logic                   last_cycle;
    logic [WORD_W-1:0]      sel_word;
    logic [WORD_W-1:0]      value_q;
    logic [STICKY_BITS-1:0] sticky_q;
    logic [DIGITS-1:0]      an_q;
    seg_t                   cat_q;
    seg_t                   cat_d;
    logic [3:0]             nibble;
    logic                   upper_zero;

    seg_scan_timer #(
        .DIGITS      (DIGITS),
        .SCAN_PERIOD (SCAN_PERIOD)
    ) u_timer (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .index_out      (index),
        .last_cycle_out (last_cycle)
    );

    // Out-of-range selects fall back to channel 0.
    always_comb begin
        sel_word = bus.chan_in[WORD_W-1:0];
        for (int k = 1; k < NUM_CHANNELS; k++) begin
            if (int'(bus.sel_in) == k) sel_word = bus.chan_in[k*WORD_W +: WORD_W];
        end
    end

    // Walk from the top nibble down so "all higher nibbles zero" accumulates.
    always_comb begin
        logic nz_acc;
        nz_acc     = 1'b0;
        nibble     = '0;
        upper_zero = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_acc = nz_acc | (value_q[i*4 +: 4] != 4'h0);
            if (int'(index) == i) begin
                nibble     = value_q[i*4 +: 4];
                upper_zero = !nz_acc && (i != 0);
            end
        end
    end

    always_comb begin
        if (last_cycle)                               cat_d = SEG_BLANK;
        else if ((BLANK_LEADING != 0) && upper_zero)  cat_d = SEG_BLANK;
        else                                          cat_d = hex_to_seg(nibble);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            value_q  <= '0;
            sticky_q <= '0;
            an_q     <= '1;
            cat_q    <= SEG_BLANK;
        end else begin
            if (!bus.freeze_in) value_q <= sel_word;
            // A set arriving with a clear survives the clear.
            sticky_q <= bus.sticky_clr_in ? bus.sticky_set_in
                                          : (sticky_q | bus.sticky_set_in);
            an_q     <= ~(DIGITS'(1) << index);
            cat_q    <= cat_d;
        end
    end

    assign bus.value_out  = value_q;
    assign bus.sticky_out = sticky_q;
    assign bus.an_out     = an_q;
    assign bus.cat_out    = cat_q;

endmodule

// File: tb/tb_seg_debug_display.sv
// Randomised bench for seg_debug_display against a cycle-count reference model;
// two instances share stimulus, one with leading-zero blanking enabled.
module tb_seg_debug_display;
    import seg_debug_pkg::*;

    localparam int NCH = 3;
    localparam int DIG = 4;
    localparam int SP  = 4;
    localparam int SB  = 8;
    localparam int W   = DIG * 4;

    localparam logic [6:0] OFF = 7'h7F;
    localparam logic [6:0] HEX_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_debug_display_if #(.NUM_CHANNELS(NCH), .DIGITS(DIG), .STICKY_BITS(SB)) bus_a ();
    seg_debug_display_if #(.NUM_CHANNELS(NCH), .DIGITS(DIG), .STICKY_BITS(SB)) bus_b ();

    seg_debug_display #(
        .NUM_CHANNELS(NCH), .DIGITS(DIG), .SCAN_PERIOD(SP), .STICKY_BITS(SB), .BLANK_LEADING(0)
    ) dut_a (.clk_in(clk), .rst_in(rst_n), .bus(bus_a));

    seg_debug_display #(
        .NUM_CHANNELS(NCH), .DIGITS(DIG), .SCAN_PERIOD(SP), .STICKY_BITS(SB), .BLANK_LEADING(1)
    ) dut_b (.clk_in(clk), .rst_in(rst_n), .bus(bus_b));

    logic [W-1:0] chan [NCH];
    logic [1:0]   sel;
    logic         freeze;
    logic [SB-1:0] set_v;
    logic         clr;

    int n_edges;
    logic [W-1:0]  m_value;
    logic [SB-1:0] m_sticky;
    logic [DIG-1:0] m_an;
    logic [6:0]    m_cat_a, m_cat_b;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply();
        bus_a.chan_in       = {chan[2], chan[1], chan[0]};
        bus_b.chan_in       = {chan[2], chan[1], chan[0]};
        bus_a.sel_in        = sel;
        bus_b.sel_in        = sel;
        bus_a.freeze_in     = freeze;
        bus_b.freeze_in     = freeze;
        bus_a.sticky_set_in = set_v;
        bus_b.sticky_set_in = set_v;
        bus_a.sticky_clr_in = clr;
        bus_b.sticky_clr_in = clr;
    endtask

    function automatic logic [6:0] model_cat(input logic [W-1:0] v, input int idx,
                                             input bit blank_en, input bit last);
        int nib;
        nib = int'((v >> (4 * idx)) & W'(15));
        if (last) return OFF;
        if (blank_en && idx > 0 && (v >> (4 * idx)) == 0) return OFF;
        return HEX_TBL[nib];
    endfunction

    task automatic model_reset();
        n_edges  = 0;
        m_value  = '0;
        m_sticky = '0;
        m_an     = '1;
        m_cat_a  = OFF;
        m_cat_b  = OFF;
    endtask

    // After n edges since release: slot counter = n mod SP, digit = (n / SP) mod DIG.
    task automatic model_edge();
        int cnt, idx, s;
        if (!rst_n) return;
        n_edges++;
        cnt     = n_edges % SP;
        idx     = (n_edges / SP) % DIG;
        m_cat_a = model_cat(m_value, idx, 1'b0, cnt == SP - 1);
        m_cat_b = model_cat(m_value, idx, 1'b1, cnt == SP - 1);
        m_an    = ~(DIG'(1) << idx);
        s       = (int'(sel) < NCH) ? int'(sel) : 0;
        if (!freeze) m_value = chan[s];
        m_sticky = clr ? set_v : (m_sticky | set_v);
    endtask

    task automatic check_all();
        check("a.value",  32'(bus_a.value_out),  32'(m_value));
        check("a.sticky", 32'(bus_a.sticky_out), 32'(m_sticky));
        check("a.an",     32'(bus_a.an_out),     32'(m_an));
        check("a.cat",    32'(bus_a.cat_out),    32'(m_cat_a));
        check("b.value",  32'(bus_b.value_out),  32'(m_value));
        check("b.sticky", 32'(bus_b.sticky_out), 32'(m_sticky));
        check("b.an",     32'(bus_b.an_out),     32'(m_an));
        check("b.cat",    32'(bus_b.cat_out),    32'(m_cat_b));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < NCH; k++)
            chan[k] = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
        sel    = 2'($urandom_range(0, 3));
        freeze = ($urandom_range(0, 3) == 0);
        set_v  = ($urandom_range(0, 3) == 0) ? SB'(1 << $urandom_range(0, SB - 1)) : '0;
        clr    = ($urandom_range(0, 11) == 0);
        apply();
    endtask

    initial begin
        for (int k = 0; k < NCH; k++) chan[k] = '0;
        sel = '0; freeze = 1'b0; set_v = '0; clr = 1'b0;
        apply();
        model_reset();
        #12;
        check_all();

        // Select/decode: chan 2 = 1A8F, scan two full rotations.
        @(negedge clk);
        chan[2] = 16'h1A8F; chan[1] = 16'hBEEF; sel = 2'd2;
        apply();
        rst_n = 1'b1;
        step();
        check("dir.sel2", 32'(bus_a.value_out), 32'h1A8F);
        run(2 * SP * DIG);

        // Freeze holds value despite input changes; release recaptures.
        freeze = 1'b1; apply(); step();
        chan[2] = 16'h1234; sel = 2'd0; apply();
        run(6);
        check("dir.freeze", 32'(bus_a.value_out), 32'h1A8F);
        freeze = 1'b0; apply(); step();
        check("dir.unfreeze", 32'(bus_a.value_out), 32'h0000);

        // Sticky set, hold, then clear with simultaneous set.
        set_v = 8'h02; apply(); step();
        set_v = 8'h00; apply(); step();
        check("dir.sticky_hold", 32'(bus_a.sticky_out), 32'h02);
        clr = 1'b1; set_v = 8'h08; apply(); step();
        check("dir.sticky_clr", 32'(bus_a.sticky_out), 32'h08);
        clr = 1'b0; set_v = 8'h00; apply();

        // Leading-zero blanking patterns.
        chan[0] = 16'h0050; apply(); run(SP * DIG + 2);
        chan[0] = 16'h0000; apply(); run(SP * DIG + 2);

        // Out-of-range select falls back to channel 0.
        chan[0] = 16'hC0DE; sel = 2'd3; apply(); step();
        check("dir.sel_oor", 32'(bus_a.value_out), 32'hC0DE);

        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            step();
        end

        // Asynchronous reset between edges, mid-scan.
        @(posedge clk);
        model_edge();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        run(2);
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_debug_display.md
Name: seg_debug_display

Overview:
- Parametrised successor to the board's fixed 8-digit seven-segment debug display path.
- Takes NUM_CHANNELS debug words from anywhere in the console (SPI controller state, program ROM words, CPU PC, and so on) and selects one at run time.
- Optionally freezes the selected value, keeps sticky event flags (such as "sys_rst seen"), and time-multiplexes the value onto DIGITS active-low seven-segment digits with optional leading-zero blanking.
- Sits in top_level between the debug sources and the ss0/ss1 anode/cathode pins.

Parameters:
- NUM_CHANNELS, 4, number of selectable debug input words (>=1).
- DIGITS, 8, number of hex digits driven (1..8); each channel word is DIGITS*4 bits wide.
- SCAN_PERIOD, 100000, clk_in cycles each digit stays lit (>=2).
- STICKY_BITS, 8, number of sticky event flags.
- BLANK_LEADING, 0, when 1, leading zero digits are blanked (digit 0 is never blanked).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous, active-low.
- chan_in  input  NUM_CHANNELS*DIGITS*4  packed debug words; channel k occupies bits [k*DIGITS*4 +: DIGITS*4].
- sel_in  input  max(1,$clog2(NUM_CHANNELS))  channel select; values >= NUM_CHANNELS select channel 0.
- freeze_in  input  1  level; while high, the displayed value is held.
- sticky_set_in  input  STICKY_BITS  per-bit set pulses/levels.
- sticky_clr_in  input  1  clears all sticky flags.
- sticky_out  output  STICKY_BITS  sticky flag state, intended for LEDs.
- value_out  output  DIGITS*4  currently latched display value.
- cat_out  output  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}.
- an_out  output  DIGITS  anodes, active-low, one-hot-low.

Behaviour:
- Reset (rst_in low, asynchronous):
  - value_out=0, sticky_out=0.
  - Scan counter=0, digit index=0.
  - an_out=all ones (all digits off), cat_out=7'h7F.
  - On release, scanning starts from digit 0 on the first clk_in edge.
- Capture:
  - Each clk_in edge with freeze_in low: value_out <= selected channel word.
  - Latency is 1 cycle from chan_in/sel_in to value_out.
  - freeze_in high: value_out holds. sel_in and chan_in changes are ignored until freeze_in falls; the capture on the next edge after it falls uses the current inputs.
- Sticky flags:
  - sticky_out <= (sticky_out | sticky_set_in) when sticky_clr_in is low.
  - sticky_out <= sticky_set_in when sticky_clr_in is high; a set in the same cycle as a clear wins for that bit, so no event is lost.
  - Flags are unaffected by freeze_in.
- Scan timer:
  - Counter runs 0..SCAN_PERIOD-1 and wraps.
  - On wrap, digit index advances by 1 modulo DIGITS (DIGITS-1 -> 0).
  - If DIGITS=1, the index stays 0 and an_out stays 0 after the first edge.
- Output stage (registered):
  - an_out and cat_out update on the same edge as the index changes and reflect the new index: an_out = ~(1<<index), cat_out = hex pattern of nibble value_out[index*4 +: 4].
  - Within a digit's slot, a change in value_out appears on cat_out 1 cycle later.
  - Digit 0 is the least-significant nibble on the rightmost anode.
- Hex patterns (active-low {g..a}): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
- Blanking (BLANK_LEADING=1):
  - A digit i>0 is blanked when it and all higher nibbles are zero.
  - A blanked digit drives cat_out=7'h7F; its anode is still driven low.
- Anti-ghosting: on the last cycle of each slot (counter=SCAN_PERIOD-1), cat_out=7'h7F.
- Reset mid-scan immediately forces the reset values above; there is no partial-state recovery.

Decomposition:
- Package seg_debug_pkg:
  - SEG_BLANK constant (7'h7F).
  - hex_to_seg function returning the 16-entry active-low table.
  - Typedef seg_t (logic [6:0]).
- One sub-module, seg_scan_timer: the SCAN_PERIOD counter plus the modulo-DIGITS index, emitting index_out and last_cycle_out.
- Capture, sticky logic and output registers stay in seg_debug_display.

Test Plan:
- Reset/scan order: DIGITS=4, SCAN_PERIOD=4. Assert then release rst_in -> an_out=4'hF during reset; after release, an_out cycles E,D,B,7,E with each value held 4 cycles.
- Decode and select: chan 0=16'h0000, chan 2=16'h1A8F, sel_in=2 -> value_out=16'h1A8F after 1 cycle; cat_out per slot is 7'h0E, 7'h00, 7'h08, 7'h79, with 7'h7F on each slot's last cycle.
- Freeze: freeze_in=1, then change chan 2 to 16'h1234 and sel_in to 0 -> value_out stays 16'h1A8F. Drop freeze_in -> value_out=16'h0000 on the next edge.
- Sticky: pulse sticky_set_in[1] -> sticky_out=8'h02 and it holds. Assert sticky_clr_in together with sticky_set_in[3] -> sticky_out=8'h08.
- Blanking: BLANK_LEADING=1, value 16'h0050 -> digits 3 and 2 show 7'h7F, digit 1 shows 7'h12, digit 0 shows 7'h40. Value 16'h0000 -> only digit 0 shows 7'h40.
- Out-of-range select and async reset: NUM_CHANNELS=3, sel_in=3 -> value_out=chan 0. Drop rst_in between clock edges -> all outputs reach reset values before the next edge.
